// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner.
// Holds the FSM state encoding, the default 50 MHz timing constants and a
// counter width helper used by the conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  // Defaults for a 50 MHz system clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;   // 10 ms
  localparam int unsigned DEF_HOLD_CYCLES     = 25000000; // 0.5 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 5000000;  // 0.1 s

  // Width of a counter that must hold 0..n-1; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Signal bundle between a raw key pin and its conditioned outputs.
//   btn_raw       : raw key pin (asynchronous, may bounce)
//   btn_level     : debounced level, 1 = pressed
//   press_pulse   : one-cycle strobe on press and on each auto-repeat
//   release_pulse : one-cycle strobe on release
//   repeating     : high while auto-repeat is active
// master: drives the pin, observes the outputs. slave: the conditioner.
interface btn_conditioner_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeating;

  modport master (
    output btn_raw,
    input  btn_level, press_pulse, release_pulse, repeating
  );

  modport slave (
    input  btn_raw,
    output btn_level, press_pulse, release_pulse, repeating
  );
endinterface

// File: rtl/btn_conditioner_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
//   clk, rst_n : clock and asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronised output
// Both flops reset to RESET_VAL so the output holds the idle level of the
// input from reset onwards.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Single-channel push-button front end: synchronise, debounce, and emit
// one-cycle press/release strobes plus a debounced level.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : btn_conditioner_if.slave (btn_raw in; btn_level, press_pulse,
//           release_pulse, repeating out)
// Optional auto-repeat is compiled in when BTN_AUTOREPEAT_EN is defined;
// otherwise the hold/repeat timer and REPEAT state are absent and
// repeating is tied low.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter bit          RAW_ACTIVE_LOW  = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input logic                clk,
  input logic                rst_n,
  btn_conditioner_if.slave   bus
);

  localparam int unsigned   DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser flops idle at the released pin level
  logic raw_s;
  logic pressed_s;

  sync_2ff #(
    .RESET_VAL (RAW_ACTIVE_LOW ? 1'b1 : 1'b0)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.btn_raw),
    .q     (raw_s)
  );

  assign pressed_s = RAW_ACTIVE_LOW ? ~raw_s : raw_s;

  btn_state_t      state, state_n;
  logic [DB_W-1:0] db_cnt, db_cnt_n;
  logic            level_q, level_n;
  logic            press_q, press_n;
  logic            release_q, release_n;
  logic            disagree, db_done, press_ev, release_ev;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned TMR_W =
    cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_MAX   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REPEAT_MAX = TMR_W'(REPEAT_CYCLES - 1);

  logic [TMR_W-1:0] timer, timer_n;
  logic             rep_q;
  logic             tmr_run;
`endif

  always_comb begin
    disagree   = (pressed_s != level_q);
    db_done    = disagree && (db_cnt == DB_MAX);
    press_ev   = db_done && !level_q;
    release_ev = db_done && level_q;

    db_cnt_n  = (disagree && !db_done) ? db_cnt + 1'b1 : '0;
    level_n   = db_done ? ~level_q : level_q;
    press_n   = press_ev;
    release_n = release_ev;
    state_n   = state;
`ifdef BTN_AUTOREPEAT_EN
    timer_n   = timer;
    // A non-zero debounce count means a level change is pending; the
    // timer holds so no repeat fires while a release is being qualified.
    tmr_run   = (db_cnt == '0);
`endif

    case (state)
      IDLE: begin
        if (press_ev) begin
          state_n = HELD;
`ifdef BTN_AUTOREPEAT_EN
          timer_n = '0;
`endif
        end
      end

      HELD: begin
        if (release_ev) begin
          state_n = IDLE;
`ifdef BTN_AUTOREPEAT_EN
          timer_n = '0;
        end else if (tmr_run) begin
          if (timer == HOLD_MAX) begin
            press_n = 1'b1;
            state_n = REPEAT;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
`endif
        end
      end

`ifdef BTN_AUTOREPEAT_EN
      REPEAT: begin
        // Release is tested first so it wins over a coincident expiry
        if (release_ev) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (tmr_run) begin
          if (timer == REPEAT_MAX) begin
            press_n = 1'b1;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
      end
`endif

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      db_cnt    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state     <= state_n;
      db_cnt    <= db_cnt_n;
      level_q   <= level_n;
      press_q   <= press_n;
      release_q <= release_n;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      rep_q <= 1'b0;
    end else begin
      timer <= timer_n;
      rep_q <= (state_n == REPEAT);
    end
  end

  assign bus.repeating = rep_q;
`else
  assign bus.repeating = 1'b0;
`endif

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_conditioner_if bus ();

  btn_conditioner #(
    .RAW_ACTIVE_LOW  (1'b1),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    bit is_press;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the next expected event exactly
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse: expected press=%0d at cycle %0d, not seen by cycle %0d",
                 exp_q[0].is_press, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (bus.press_pulse && bus.release_pulse) begin
        checks++;
        errors++;
        $display("FAIL pulse_overlap: press=1 release=1 at cycle %0d, required exclusive", cyc);
      end else if (bus.press_pulse || bus.release_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: press=%0d release=%0d at cycle %0d, required none",
                   bus.press_pulse, bus.release_pulse, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc !== cyc || mon_e.is_press !== bus.press_pulse) begin
            errors++;
            $display("FAIL pulse_event: got press=%0d at cycle %0d, required press=%0d at cycle %0d",
                     bus.press_pulse, cyc, mon_e.is_press, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_ev(input int c, input bit p);
    exp_q.push_back('{c, p});
  endtask

  task automatic test_reset();
    bus.btn_raw = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.btn_level, bus.press_pulse, bus.release_pulse, bus.repeating} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000",
               {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.repeating});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.btn_level !== 1'b0) begin
      errors++;
      $display("FAIL idle_level: got %b, required 0", bus.btn_level);
    end
  endtask

  task automatic test_clean_press();
    int c0, c1;
    c0 = cyc;
    bus.btn_raw = 1'b0;
    expect_ev(c0 + 6, 1'b1);
    at_cycle(c0 + 5);
    checks++;
    if (bus.btn_level !== 1'b0) begin
      errors++;
      $display("FAIL press_level_early: got %b at cycle %0d, required 0", bus.btn_level, cyc);
    end
    at_cycle(c0 + 6);
    checks++;
    if (bus.btn_level !== 1'b1) begin
      errors++;
      $display("FAIL press_level: got %b at cycle %0d, required 1", bus.btn_level, cyc);
    end
    at_cycle(c0 + 7);
    c1 = cyc;
    bus.btn_raw = 1'b1;
    expect_ev(c1 + 6, 1'b0);
    at_cycle(c1 + 6);
    checks++;
    if (bus.btn_level !== 1'b0) begin
      errors++;
      $display("FAIL release_level: got %b at cycle %0d, required 0", bus.btn_level, cyc);
    end
    at_cycle(c1 + 12);
  endtask

  task automatic test_bounce();
    int c0, c1;
    c0 = cyc;
    for (int i = 0; i <= 6; i++) begin
      at_cycle(c0 + 2 * i);
      bus.btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    expect_ev(c0 + 18, 1'b1);
    checks++;
    if (bus.btn_level !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level: got %b at cycle %0d, required 0", bus.btn_level, cyc);
    end
    at_cycle(c0 + 18);
    checks++;
    if (bus.btn_level !== 1'b1) begin
      errors++;
      $display("FAIL bounce_accept: got %b at cycle %0d, required 1", bus.btn_level, cyc);
    end
    at_cycle(c0 + 19);
    c1 = cyc;
    bus.btn_raw = 1'b1;
    expect_ev(c1 + 6, 1'b0);
    at_cycle(c1 + 12);
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int p;
    p = cyc + 6;
    bus.btn_raw = 1'b0;
    expect_ev(p, 1'b1);
    expect_ev(p + 10, 1'b1);
    expect_ev(p + 13, 1'b1);
    expect_ev(p + 16, 1'b1);
    // glitch p+14..p+16 freezes the timer for two cycles
    for (int k = 21; k <= 42; k += 3) expect_ev(p + k, 1'b1);
    expect_ev(p + 46, 1'b0);
    at_cycle(p + 9);
    checks++;
    if (bus.repeating !== 1'b0) begin
      errors++;
      $display("FAIL repeating_early: got %b at cycle %0d, required 0", bus.repeating, cyc);
    end
    at_cycle(p + 10);
    checks++;
    if (bus.repeating !== 1'b1) begin
      errors++;
      $display("FAIL repeating_start: got %b at cycle %0d, required 1", bus.repeating, cyc);
    end
    at_cycle(p + 14);
    bus.btn_raw = 1'b1;
    at_cycle(p + 16);
    bus.btn_raw = 1'b0;
    at_cycle(p + 19);
    checks++;
    if ({bus.btn_level, bus.repeating} !== 2'b11) begin
      errors++;
      $display("FAIL glitch_hold: got level,repeating=%b at cycle %0d, required 11",
               {bus.btn_level, bus.repeating}, cyc);
    end
    at_cycle(p + 40);
    bus.btn_raw = 1'b1;
    at_cycle(p + 46);
    checks++;
    if ({bus.btn_level, bus.repeating} !== 2'b00) begin
      errors++;
      $display("FAIL repeat_release: got level,repeating=%b at cycle %0d, required 00",
               {bus.btn_level, bus.repeating}, cyc);
    end
    at_cycle(p + 56);
  endtask

  task automatic test_collision();
    int p;
    p = cyc + 6;
    bus.btn_raw = 1'b0;
    expect_ev(p, 1'b1);
    expect_ev(p + 10, 1'b1);
    expect_ev(p + 13, 1'b1);
    expect_ev(p + 16, 1'b0);
    at_cycle(p + 10);
    bus.btn_raw = 1'b1;
    at_cycle(p + 16);
    checks++;
    if ({bus.release_pulse, bus.press_pulse} !== 2'b10) begin
      errors++;
      $display("FAIL collision: got release,press=%b at cycle %0d, required 10",
               {bus.release_pulse, bus.press_pulse}, cyc);
    end
    at_cycle(p + 26);
  endtask
`else
  task automatic test_hold_no_repeat();
    int p;
    p = cyc + 6;
    bus.btn_raw = 1'b0;
    expect_ev(p, 1'b1);
    expect_ev(p + 46, 1'b0);
    for (int k = 10; k <= 40; k += 10) begin
      at_cycle(p + k);
      checks++;
      if ({bus.btn_level, bus.repeating} !== 2'b10) begin
        errors++;
        $display("FAIL hold_state: got level,repeating=%b at cycle %0d, required 10",
                 {bus.btn_level, bus.repeating}, cyc);
      end
    end
    bus.btn_raw = 1'b1;
    at_cycle(p + 56);
  endtask
`endif

  task automatic test_reset_mid_hold();
    int p, c, c1;
    p = cyc + 6;
    bus.btn_raw = 1'b0;
    expect_ev(p, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
    expect_ev(p + 10, 1'b1);
    at_cycle(p + 11);
    checks++;
    if (bus.repeating !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_repeat: got %b at cycle %0d, required 1", bus.repeating, cyc);
    end
`else
    at_cycle(p + 11);
    checks++;
    if (bus.btn_level !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_level: got %b at cycle %0d, required 1", bus.btn_level, cyc);
    end
`endif
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.btn_level, bus.press_pulse, bus.release_pulse, bus.repeating} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b, required 0000",
               {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.repeating});
    end
    repeat (3) @(negedge clk);
    c = cyc;
    rst_n = 1'b1;
    expect_ev(c + 6, 1'b1);
    at_cycle(c + 5);
    checks++;
    if (bus.btn_level !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_early: got %b at cycle %0d, required 0", bus.btn_level, cyc);
    end
    at_cycle(c + 6);
    checks++;
    if ({bus.btn_level, bus.repeating} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_press: got level,repeating=%b at cycle %0d, required 10",
               {bus.btn_level, bus.repeating}, cyc);
    end
    at_cycle(c + 7);
    c1 = cyc;
    bus.btn_raw = 1'b1;
    expect_ev(c1 + 6, 1'b0);
    at_cycle(c1 + 12);
  endtask

  initial begin
    bus.btn_raw = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
    test_collision();
`else
    test_hold_no_repeat();
`endif
    test_reset_mid_hold();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
